// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: FK/CK constants, rotation and linear transforms, engine state encoding.
package sm4_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEYEXP,
      ST_READY,
      ST_RUN,
      ST_DONE
   } state_t;

   localparam logic [3:0][31:0] FK = {32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

   // CK table entry i: byte j (MSB first) is (4i+j)*7 mod 256.
   function automatic logic [31:0] ck(input logic [4:0] i);
      logic [31:0] r;
      r = '0;
      for (int j = 0; j < 4; j++) begin
         r[31-8*j -: 8] = {1'b0, i, 2'(j)} * 8'd7;
      end
      return r;
   endfunction

   function automatic logic [31:0] rot32(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] lin(input logic [31:0] b);
      return b ^ rot32(b, 2) ^ rot32(b, 10) ^ rot32(b, 18) ^ rot32(b, 24);
   endfunction

   function automatic logic [31:0] lin_key(input logic [31:0] b);
      return b ^ rot32(b, 13) ^ rot32(b, 23);
   endfunction

endpackage

// File: rtl/sm4_tau.sv
// SM4 non-linear layer: four independent byte S-box lookups, purely combinational.
module sm4_tau (
   input  logic [31:0] a,
   output logic [31:0] b
);

   localparam logic [7:0] SBOX [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   assign b = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};

endmodule

// File: rtl/sm4_dec_core.sv
// Iterative SM4 decrypt: 32-cycle key expansion, 33-cycle block latency, result held until dout_ready_i.
// Define SM4_ENC_EN to add mode_i (1 = encrypt with forward round-key order).
module sm4_dec_core
   import sm4_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [127:0] key_i,
   input  logic         key_valid_i,
   output logic         key_ready_o,
   input  logic [127:0] din_i,
   input  logic         din_valid_i,
`ifdef SM4_ENC_EN
   input  logic         mode_i,
`endif
   output logic         din_ready_o,
   output logic [127:0] dout_o,
   output logic         dout_valid_o,
   input  logic         dout_ready_i,
   output logic         busy_o
);

   state_t       state;
   logic [4:0]   cnt;
   logic [127:0] w;
   logic [31:0]  rk [32];
   logic [127:0] dout_q;
   logic         key_rdy_q, din_win_q, dout_vld_q, busy_q;
   logic [4:0]   rk_idx;
   logic [31:0]  rk_sel, f_in, t_out, w_new;
   logic         key_fire, din_fire, dout_fire;

`ifdef SM4_ENC_EN
   logic enc_q;
   assign rk_idx = enc_q ? cnt : ~cnt;
`else
   assign rk_idx = ~cnt;
`endif

   assign key_ready_o  = key_rdy_q;
   assign din_ready_o  = din_win_q & ~key_valid_i;
   assign dout_valid_o = dout_vld_q;
   assign dout_o       = dout_q;
   assign busy_o       = busy_q;

   assign key_fire  = key_valid_i & key_rdy_q;
   assign din_fire  = din_valid_i & din_ready_o;
   assign dout_fire = dout_vld_q & dout_ready_i;

   // The working register holds K(i)..K(i+3) during KEYEXP and X(i)..X(i+3) during RUN.
   assign rk_sel = rk[rk_idx];
   assign f_in   = w[95:64] ^ w[63:32] ^ w[31:0] ^ ((state == ST_KEYEXP) ? ck(cnt) : rk_sel);

   sm4_tau u_tau (
      .a (f_in),
      .b (t_out)
   );

   assign w_new = w[127:96] ^ ((state == ST_KEYEXP) ? lin_key(t_out) : lin(t_out));

   always_ff @(posedge clk_i) begin
      if (!rst_i && state == ST_KEYEXP) begin
         rk[cnt] <= w_new;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         w          <= '0;
         dout_q     <= '0;
         key_rdy_q  <= 1'b1;
         din_win_q  <= 1'b0;
         dout_vld_q <= 1'b0;
         busy_q     <= 1'b0;
`ifdef SM4_ENC_EN
         enc_q      <= 1'b0;
`endif
      end else if (key_fire) begin
         state     <= ST_KEYEXP;
         cnt       <= '0;
         w         <= key_i ^ FK;
         key_rdy_q <= 1'b0;
         din_win_q <= 1'b0;
         busy_q    <= 1'b1;
      end else begin
         case (state)
            ST_KEYEXP: begin
               w   <= {w[95:0], w_new};
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state     <= ST_READY;
                  key_rdy_q <= 1'b1;
                  din_win_q <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            ST_READY: begin
               if (din_fire) begin
                  state     <= ST_RUN;
                  cnt       <= '0;
                  w         <= din_i;
                  key_rdy_q <= 1'b0;
                  din_win_q <= 1'b0;
                  busy_q    <= 1'b1;
`ifdef SM4_ENC_EN
                  enc_q     <= mode_i;
`endif
               end
            end
            ST_RUN: begin
               w   <= {w[95:0], w_new};
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state      <= ST_DONE;
                  dout_vld_q <= 1'b1;
                  dout_q     <= {w_new, w[31:0], w[63:32], w[95:64]};
               end
            end
            ST_DONE: begin
               if (dout_fire) begin
                  state      <= ST_READY;
                  dout_vld_q <= 1'b0;
                  key_rdy_q  <= 1'b1;
                  din_win_q  <= 1'b1;
                  busy_q     <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sm4_dec_core.sv
// Directed bench for sm4_dec_core using the standard SM4 vector; inputs driven and outputs sampled on the falling edge.
module tb_sm4_dec_core;

   localparam logic [127:0] KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [127:0] PT  = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [127:0] CT  = 128'h681EDF34D206965E86B3E94F536E4246;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [127:0] key_i, din_i, dout_o;
   logic         key_valid_i, key_ready_o, din_valid_i, din_ready_o;
   logic         dout_valid_o, dout_ready_i, busy_o;
`ifdef SM4_ENC_EN
   logic         mode_i;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk_i = ~clk_i;

   sm4_dec_core dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .key_i        (key_i),
      .key_valid_i  (key_valid_i),
      .key_ready_o  (key_ready_o),
      .din_i        (din_i),
      .din_valid_i  (din_valid_i),
`ifdef SM4_ENC_EN
      .mode_i       (mode_i),
`endif
      .din_ready_o  (din_ready_o),
      .dout_o       (dout_o),
      .dout_valid_o (dout_valid_o),
      .dout_ready_i (dout_ready_i),
      .busy_o       (busy_o)
   );

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // sel: 0 = din_ready_o high, 1 = dout_valid_o high, 2 = busy_o low; n = falling edges waited
   task automatic wait_sig(input int sel, output int n);
      n = 0;
      while (n < 200 && !((sel == 0 && din_ready_o) || (sel == 1 && dout_valid_o) ||
                          (sel == 2 && !busy_o))) begin
         tick();
         n++;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_key_ready"},  128'(key_ready_o),  128'd1);
      chk({tag, "_din_ready"},  128'(din_ready_o),  128'd0);
      chk({tag, "_dout_valid"}, 128'(dout_valid_o), 128'd0);
      chk({tag, "_dout"},       dout_o,             128'd0);
      chk({tag, "_busy"},       128'(busy_o),       128'd0);
   endtask

   initial begin
      int   n;
      logic seen_rdy, seen_vld;
      rst_i = 1'b1; key_i = '0; key_valid_i = 1'b0; din_i = '0; din_valid_i = 1'b0;
      dout_ready_i = 1'b0;
`ifdef SM4_ENC_EN
      mode_i = 1'b0;
`endif
      repeat (3) tick();
      chk_reset_outputs("reset");
      rst_i = 1'b0;
      tick();

      // key load; an early block offer must be ignored until READY
      key_i = KEY; key_valid_i = 1'b1; din_i = CT; din_valid_i = 1'b1;
      #1;
      chk("idle_din_ready", 128'(din_ready_o), 128'd0);
      tick();
      key_valid_i = 1'b0; key_i = ~KEY;
      chk("keyexp_busy", 128'(busy_o), 128'd1);
      chk("keyexp_key_ready", 128'(key_ready_o), 128'd0);
      wait_sig(0, n);
      chk("keyexp_cycles", 128'(n), 128'd32);
      chk("ready_busy", 128'(busy_o), 128'd0);
      tick();
      din_i = ~CT; din_valid_i = 1'b0;
      wait_sig(1, n);
      chk("dec_latency", 128'(n + 1), 128'd33);
      chk("dec_std_vector", dout_o, PT);
      chk("done_din_ready", 128'(din_ready_o), 128'd0);
      chk("done_key_ready", 128'(key_ready_o), 128'd0);
      chk("done_busy", 128'(busy_o), 128'd1);

      // backpressure with a competing block offer
      din_i = CT; din_valid_i = 1'b1;
      repeat (10) begin
         tick();
         chk("bp_dout", dout_o, PT);
         chk("bp_dout_valid", 128'(dout_valid_o), 128'd1);
         chk("bp_din_ready", 128'(din_ready_o), 128'd0);
      end
      din_valid_i = 1'b0; dout_ready_i = 1'b1;
      tick();
      dout_ready_i = 1'b0;
      chk("bp_release_valid", 128'(dout_valid_o), 128'd0);
      chk("bp_release_din_ready", 128'(din_ready_o), 128'd1);
      chk("bp_release_busy", 128'(busy_o), 128'd0);

      // back-to-back blocks
      din_i = CT; din_valid_i = 1'b1; dout_ready_i = 1'b1;
      wait_sig(1, n);
      chk("b2b_first_latency", 128'(n), 128'd33);
      chk("b2b_first_dout", dout_o, PT);
      tick();
      wait_sig(1, n);
      chk("b2b_spacing", 128'(n + 1), 128'd34);
      chk("b2b_second_dout", dout_o, PT);
      din_valid_i = 1'b0;
      tick();
      dout_ready_i = 1'b0;
      chk("b2b_taken_valid", 128'(dout_valid_o), 128'd0);

      // load a wrong key, then a key offer beats a simultaneous block offer
      key_i = '0; key_valid_i = 1'b1;
      tick();
      key_valid_i = 1'b0;
      wait_sig(0, n);
      chk("zero_key_cycles", 128'(n), 128'd32);
      key_i = KEY; key_valid_i = 1'b1; din_i = CT; din_valid_i = 1'b1;
      #1;
      chk("prio_din_ready", 128'(din_ready_o), 128'd0);
      tick();
      key_valid_i = 1'b0; key_i = '0;
      chk("prio_key_taken", 128'(busy_o), 128'd1);
      wait_sig(2, n);
      chk("prio_busy_cycles", 128'(n), 128'd32);
      wait_sig(1, n);
      din_valid_i = 1'b0;
      chk("prio_latency", 128'(n), 128'd33);
      chk("prio_dout", dout_o, PT);
      dout_ready_i = 1'b1;
      tick();
      dout_ready_i = 1'b0;

      // reset while round 17 is in progress
      din_i = CT; din_valid_i = 1'b1;
      tick();
      din_valid_i = 1'b0;
      repeat (17) tick();
      rst_i = 1'b1;
      tick();
      chk_reset_outputs("midrun_reset");
      rst_i = 1'b0;
      seen_rdy = 1'b0; seen_vld = 1'b0; din_valid_i = 1'b1;
      repeat (40) begin
         tick();
         seen_rdy |= din_ready_o;
         seen_vld |= dout_valid_o;
      end
      chk("post_reset_no_din_ready", 128'(seen_rdy), 128'd0);
      chk("post_reset_no_dout_valid", 128'(seen_vld), 128'd0);
      key_i = KEY; key_valid_i = 1'b1;
      tick();
      key_valid_i = 1'b0;
      wait_sig(1, n);
      din_valid_i = 1'b0;
      chk("post_reset_cycles", 128'(n), 128'd65);
      chk("post_reset_dout", dout_o, PT);
      dout_ready_i = 1'b1;
      tick();
      dout_ready_i = 1'b0;

`ifdef SM4_ENC_EN
      mode_i = 1'b1; din_i = PT; din_valid_i = 1'b1;
      wait_sig(1, n);
      din_valid_i = 1'b0;
      chk("enc_latency", 128'(n), 128'd33);
      chk("enc_std_vector", dout_o, CT);
      dout_ready_i = 1'b1;
      tick();
      dout_ready_i = 1'b0;
      mode_i = 1'b0; din_i = CT; din_valid_i = 1'b1;
      wait_sig(1, n);
      din_valid_i = 1'b0;
      chk("enc_loopback_dec", dout_o, PT);
      dout_ready_i = 1'b1;
      tick();
      dout_ready_i = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sm4_dec_core.md
# sm4_dec_core

Iterative SM4 block-decryption engine that processes one round per clock and computes one key-schedule round per clock. It expands a loaded 128-bit master key forward into a 32-entry round-key buffer, then applies the round keys in reverse order (rk31 first) to each 128-bit ciphertext block. It sits beside the encryption datapath in the SM4 flow and shares its S-box and round-function primitives.

## Interface
- No parameters.
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- key_i  in  128  master key MK; MK0 = [127:96].
- key_valid_i  in  1  key offer.
- key_ready_o  out  1  key accepted when key_valid_i && key_ready_o.
- din_i  in  128  ciphertext block; X0 = [127:96].
- din_valid_i  in  1  block offer.
- din_ready_o  out  1  block accepted when din_valid_i && din_ready_o.
- dout_o  out  128  plaintext {X35,X34,X33,X32}.
- dout_valid_o  out  1  result valid; held until taken.
- dout_ready_i  in  1  result taken when dout_valid_o && dout_ready_i.
- busy_o  out  1  high in KEYEXP, RUN and DONE.

## Operation
- States: IDLE (no valid key), KEYEXP, READY, RUN, DONE.
- IDLE: key_ready_o=1, din_ready_o=0. A key handshake moves to KEYEXP and loads K0..K3 = MK ^ FK, with FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
- KEYEXP: counter i counts 0..31. Each cycle: K(i+4) = K(i) ^ L'(tau(K(i+1)^K(i+2)^K(i+3)^CK(i))), where L'(B) = B ^ (B<<<13) ^ (B<<<23). rk[i] is written with K(i+4). At i=31 the state moves to READY.
- READY: key_ready_o=1; din_ready_o = !key_valid_i. A key offer takes priority and re-enters KEYEXP, replacing all rk. A block handshake loads X0..X3 and moves to RUN.
- RUN: counter i counts 0..31. Each cycle: X(i+4) = X(i) ^ L(tau(X(i+1)^X(i+2)^X(i+3)^rk[31-i])), where L(B) = B ^ (B<<<2) ^ (B<<<10) ^ (B<<<18) ^ (B<<<24). At i=31 the state moves to DONE.
- DONE: dout_valid_o=1 and dout_o is stable. The output handshake returns to READY. Both ready outputs are 0.
- tau applies the SM4 S-box to each byte of its 32-bit input independently.
- All rotations are 32-bit circular left rotations. XOR is the only arithmetic.
- Counter wraps 31 -> 0 on the state exit.
- Key and block offers outside their ready windows are ignored. Inputs are sampled only on the handshake cycle.
- Reset at any time: state goes to IDLE, the current key is invalidated, and any in-flight block is discarded without output. rk contents are not cleared and are unused until the next KEYEXP completes.

## Timing
- Reset values: key_ready_o=1, din_ready_o=0, dout_valid_o=0, dout_o=0, busy_o=0.
- Key accepted at edge T: KEYEXP occupies T+1..T+32, and din_ready_o rises at T+33.
- Block accepted at edge T: RUN occupies T+1..T+32, and dout_valid_o rises at T+33. Latency is 33 cycles.
- Output taken at edge T: din_ready_o=1 at T+1, giving a throughput of 1 block per 34 cycles with no stall.
- dout_ready_i held low: DONE is held indefinitely and dout_o does not change.
- No combinational path from din_i or key_i to any output. ready outputs depend only on state and key_valid_i.

## Configuration
- SM4_ENC_EN defined: adds port mode_i (in, 1), sampled at the block handshake. mode_i=1 encrypts, using rk[i] in round i. mode_i=0 decrypts, using rk[31-i].
- SM4_ENC_EN undefined: port mode_i is absent and the block always decrypts.
- Latency and handshakes are identical in both builds.

## Structure
- Shared package sm4_pkg: FK constant array, 32-entry CK table (byte j of CK(i) = (4i+j)*7 mod 256), rot32 and L/L' functions, state enum.
- Sub-module sm4_tau: 32-bit to 32-bit, four byte S-box lookups.
  - A single instance is shared between KEYEXP and RUN, which never overlap.
- rk storage: 32x32 register array, written during KEYEXP at index i, read at a mux-selected index.

## Test plan
- Standard vector: key and block both 0123456789ABCDEFFEDCBA9876543210 -> rk[0]=F12186F9, rk[31]=9124A012; decrypting 681EDF34D206965E86B3E94F536E4246 returns 0123456789ABCDEFFEDCBA9876543210 with dout_valid_o 33 cycles after the block handshake.
- Backpressure: hold dout_ready_i=0 for 10 cycles -> dout_o stable, din_ready_o=0, and no second block accepted; the release completes the handshake, and din_ready_o=1 the next cycle.
- Key priority: in READY assert key_valid_i and din_valid_i together -> din_ready_o=0, key taken, and busy_o high for 32 cycles; the block is then accepted with the new rk.
- Reset mid-RUN at round 17 -> all outputs go to reset values the next cycle, with no dout_valid_o; din_ready_o stays 0 until a new key has been expanded.
- Back-to-back: two blocks with dout_ready_i=1 -> results 34 cycles apart, each correct.
- With SM4_ENC_EN: mode_i=1 on the standard plaintext -> 681EDF34D206965E86B3E94F536E4246; looping back with mode_i=0 recovers the plaintext.
